// File: rtl/gpb_opb_pkg.sv
// Shared OPB definitions for the GPIO/loop-monitor decode: register offsets,
// CTRL/STATUS bit positions and the scan sequencer state encoding.
package gpb_opb_pkg;

   localparam logic [5:0] REG_CTRL    = 6'h00;
   localparam logic [5:0] REG_STATUS  = 6'h01;
   localparam logic [5:0] REG_SETTLE  = 6'h02;
   localparam logic [5:0] REG_CH_MASK = 6'h03;
   localparam logic [5:0] REG_RESULT  = 6'h20;

   localparam int CTRL_RUN   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_ABORT = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_TIMEOUT = 2;
   localparam int STAT_CH_LSB  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SETTLE,
      ST_CONVERT,
      ST_WAIT,
      ST_STORE
   } scan_state_t;

   // Mux bank enable: ch[4:3] picks one of four 8-input banks.
   function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
      return 4'b0001 << bank;
   endfunction

endpackage

// File: rtl/lp_mon_result_buf.sv
// 32-entry result store for the loop-monitor scan: one write port from the
// sequencer, one combinational read port for the OPB read mux.
module lp_mon_result_buf #(
   parameter int ADC_W = 12
) (
   input  logic             OPB_CLK,
   input  logic             OPB_RST,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [4:0]       wr_addr,
   input  logic [ADC_W-1:0] wr_data,
   input  logic [4:0]       rd_addr,
   output logic [ADC_W:0]   rd_entry
);

   logic [ADC_W-1:0] data_mem [32];
   logic [31:0]      valid;

   // Only the valid bits need a reset; stale data behind a clear VALID is harmless.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         valid <= '0;
      end else if (clear) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_addr] <= 1'b1;
      end
   end

   always_ff @(posedge OPB_CLK) begin
      if (wr_en) begin
         data_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_entry = {valid[rd_addr], data_mem[rd_addr]};

endmodule

// File: rtl/lp_mon_scan_seq.sv
// Autonomous loop-monitor scan sequencer: walks enabled mux channels, settles,
// handshakes one ADC conversion per channel and exposes results over OPB.
module lp_mon_scan_seq
   import gpb_opb_pkg::*;
#(
   parameter int NUM_CH      = 32,
   parameter int ADC_W       = 12,
   parameter int SETTLE_DEF  = 200,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             OPB_CLK,
   input  logic             OPB_RST,
   input  logic [31:0]      OPB_DI,
   output logic [31:0]      OPB_DO,
   input  logic [31:0]      OPB_ADDR,
   input  logic             SEQ_RE,
   input  logic             SEQ_WE,
   output logic [2:0]       LP_MON_A,
   output logic [3:0]       LP_MON_SEL,
   output logic             ADC_START,
   input  logic             ADC_DONE,
   input  logic [ADC_W-1:0] ADC_DATA,
   output logic             SCAN_IRQ
);

   localparam int              TO_W       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [5:0]      NUM_CH_L   = 6'(NUM_CH);
   localparam logic [15:0]     SETTLE_RST = 16'(SETTLE_DEF);

   scan_state_t      state;
   logic [4:0]       ch;
   logic [31:0]      scan_mask;
   logic [31:0]      mask_reg;
   logic [15:0]      settle_reg;
   logic [15:0]      settle_cnt;
   logic [TO_W-1:0]  timeout_cnt;
   logic [ADC_W-1:0] adc_q;
   logic [2:0]       sel_a;
   logic [3:0]       sel_bank;
   logic             adc_start;
   logic             scan_irq;
   logic             run;
   logic             cont;
   logic             done;
   logic             timeout_flag;
   logic [31:0]      opb_do;

   logic [5:0]       reg_addr;
   logic             ctrl_wr;
   logic             abort_req;
   logic             start_req;
   logic             ch_enabled;
   logic             last_ch;
   logic             timeout_hit;
   logic             advance;
   logic             store_en;
   logic [ADC_W:0]   rd_entry;
   logic [31:0]      rd_word;
   logic             unused_addr;

   assign reg_addr    = OPB_ADDR[5:0];
   assign unused_addr = ^OPB_ADDR[31:6];

   assign ctrl_wr    = SEQ_WE && (reg_addr == REG_CTRL);
   assign abort_req  = ctrl_wr && OPB_DI[CTRL_ABORT];
   assign start_req  = ctrl_wr && OPB_DI[CTRL_RUN] && !OPB_DI[CTRL_ABORT] && (state == ST_IDLE);

   assign ch_enabled  = scan_mask[ch] && ({1'b0, ch} < NUM_CH_L);
   assign last_ch     = (ch == 5'd31);
   assign timeout_hit = (state == ST_WAIT) && !ADC_DONE && (timeout_cnt == TO_LAST);
   assign store_en    = (state == ST_STORE);

   // A channel is finished when it is skipped, stored, or abandoned on timeout.
   assign advance = ((state == ST_SELECT) && !ch_enabled) || store_en || timeout_hit;

   // Firmware-owned configuration registers.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         settle_reg <= SETTLE_RST;
         mask_reg   <= '1;
         cont       <= 1'b0;
      end else if (SEQ_WE) begin
         case (reg_addr)
            REG_CTRL:    cont       <= OPB_DI[CTRL_CONT];
            REG_SETTLE:  settle_reg <= OPB_DI[15:0];
            REG_CH_MASK: mask_reg   <= OPB_DI;
            default:     ;
         endcase
      end
   end

   // Scan FSM. The mask is latched per pass so mid-pass mask writes take effect
   // on the next pass only; abort overrides every state transition.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         state        <= ST_IDLE;
         ch           <= '0;
         scan_mask    <= '0;
         settle_cnt   <= '0;
         timeout_cnt  <= '0;
         adc_q        <= '0;
         sel_a        <= '0;
         sel_bank     <= '0;
         adc_start    <= 1'b0;
         scan_irq     <= 1'b0;
         run          <= 1'b0;
         done         <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         adc_start <= 1'b0;
         scan_irq  <= 1'b0;
         if (ctrl_wr) begin
            done         <= 1'b0;
            timeout_flag <= 1'b0;
         end
         if (abort_req) begin
            state    <= ST_IDLE;
            run      <= 1'b0;
            sel_bank <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_req) begin
                     state     <= ST_SELECT;
                     ch        <= '0;
                     run       <= 1'b1;
                     scan_mask <= mask_reg;
                  end
               end
               ST_SELECT: begin
                  if (ch_enabled) begin
                     sel_a      <= ch[2:0];
                     sel_bank   <= bank_onehot(ch[4:3]);
                     settle_cnt <= (settle_reg == 16'd0) ? 16'd1 : settle_reg;
                     state      <= ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (settle_cnt <= 16'd1) begin
                     state     <= ST_CONVERT;
                     adc_start <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt - 16'd1;
                  end
               end
               ST_CONVERT: begin
                  state       <= ST_WAIT;
                  timeout_cnt <= '0;
               end
               ST_WAIT: begin
                  if (ADC_DONE) begin
                     adc_q <= ADC_DATA;
                     state <= ST_STORE;
                  end else if (timeout_hit) begin
                     timeout_flag <= 1'b1;
                  end else begin
                     timeout_cnt <= timeout_cnt + 1'b1;
                  end
               end
               ST_STORE: ;
               default: state <= ST_IDLE;
            endcase

            if (advance) begin
               if (last_ch) begin
                  done     <= 1'b1;
                  scan_irq <= 1'b1;
                  ch       <= '0;
                  if (cont) begin
                     state     <= ST_SELECT;
                     scan_mask <= mask_reg;
                  end else begin
                     state    <= ST_IDLE;
                     run      <= 1'b0;
                     sel_a    <= '0;
                     sel_bank <= '0;
                  end
               end else begin
                  ch    <= ch + 5'd1;
                  state <= ST_SELECT;
               end
            end
         end
      end
   end

   lp_mon_result_buf #(
      .ADC_W(ADC_W)
   ) u_result_buf (
      .OPB_CLK  (OPB_CLK),
      .OPB_RST  (OPB_RST),
      .clear    (start_req),
      .wr_en    (store_en),
      .wr_addr  (ch),
      .wr_data  (adc_q),
      .rd_addr  (reg_addr[4:0]),
      .rd_entry (rd_entry)
   );

   // OPB read mux; result entries occupy the upper half of the 6-bit window.
   always_comb begin
      rd_word = '0;
      if (reg_addr[5]) begin
         rd_word[31]          = rd_entry[ADC_W];
         rd_word[ADC_W-1:0]   = rd_entry[ADC_W-1:0];
      end else begin
         case (reg_addr)
            REG_CTRL: begin
               rd_word[CTRL_RUN]  = run;
               rd_word[CTRL_CONT] = cont;
            end
            REG_STATUS: begin
               rd_word[STAT_BUSY]             = (state != ST_IDLE);
               rd_word[STAT_DONE]             = done;
               rd_word[STAT_TIMEOUT]          = timeout_flag;
               rd_word[STAT_CH_LSB +: 5]      = ch;
            end
            REG_SETTLE:  rd_word[15:0] = settle_reg;
            REG_CH_MASK: rd_word       = mask_reg;
            default:     rd_word       = '0;
         endcase
      end
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         opb_do <= '0;
      end else begin
         opb_do <= SEQ_RE ? rd_word : 32'd0;
      end
   end

   assign OPB_DO     = opb_do;
   assign LP_MON_A   = sel_a;
   assign LP_MON_SEL = sel_bank;
   assign ADC_START  = adc_start;
   assign SCAN_IRQ   = scan_irq;

endmodule
